// File: rtl/program_loader.sv
// Program memory writer: loads a length/payload/XOR-checksum byte stream
// into 32-bit words and holds the core in reset until a good load completes.
// Ports: clk, reset_i (sync, active-high), start_i, byte_valid_i/byte_data_i/
//   byte_ready_o (stream handshake), pm_write_enable_o/pm_address_o/
//   pm_write_data_o (memory write), core_reset_o, done_o, error_o (status).
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  pm_write_enable_o,
  output logic [ADDR_WIDTH-1:0] pm_address_o,
  output logic [31:0]           pm_write_data_o,
  output logic                  core_reset_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int WW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LENGTH,
    PAYLOAD,
    CHECKSUM,
    DONE,
    ERROR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [WW-1:0] word_idx;
  logic [WW-1:0] last_word;
  logic [1:0]    byte_idx;
  logic [7:0]    csum;
  logic [31:0]   word_buf;
  logic          accept;
  logic          len_bad;
  logic          last;

  assign accept  = byte_valid_i & byte_ready_o;
  assign len_bad = (byte_data_i == 8'd0) ||
                   ({24'd0, byte_data_i} > MAX_WORDS);
  assign last    = (byte_idx == 2'd3) && (word_idx == last_word);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start_i) state_n = LENGTH;
      end
      LENGTH: begin
        if (accept) state_n = len_bad ? ERROR : PAYLOAD;
      end
      PAYLOAD: begin
        if (accept && last) state_n = CHECKSUM;
      end
      CHECKSUM: begin
        if (accept)
          state_n = (byte_data_i == csum) ? DONE : ERROR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state             <= IDLE;
      word_idx          <= '0;
      last_word         <= '0;
      byte_idx          <= '0;
      csum              <= '0;
      word_buf          <= '0;
      byte_ready_o      <= 1'b0;
      pm_write_enable_o <= 1'b0;
      pm_address_o      <= '0;
      pm_write_data_o   <= '0;
      core_reset_o      <= 1'b1;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
    end else begin
      state             <= state_n;
      pm_write_enable_o <= 1'b0;
      // Status flags follow the next state so they flip on the same edge.
      byte_ready_o <= (state_n == LENGTH) ||
                      (state_n == PAYLOAD) ||
                      (state_n == CHECKSUM);
      done_o       <= (state_n == DONE);
      error_o      <= (state_n == ERROR);
      core_reset_o <= (state_n != DONE);

      if (state == IDLE || state == DONE || state == ERROR) begin
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end

      if (state == LENGTH && accept && !len_bad)
        last_word <= WW'(byte_data_i - 8'd1);

      if (state == PAYLOAD && accept) begin
        csum     <= csum ^ byte_data_i;
        byte_idx <= byte_idx + 2'd1;
        word_buf[{byte_idx, 3'b000} +: 8] <= byte_data_i;
        if (byte_idx == 2'd3) begin
          pm_write_enable_o <= 1'b1;
          pm_address_o      <= ADDR_WIDTH'({word_idx, 2'b00});
          pm_write_data_o   <= {byte_data_i, word_buf[23:0]};
          // Index stays on the last word so it never passes MAX_WORDS-1.
          if (!last) word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad loads, length bounds,
// gaps, ignored start/bytes, reset mid-load and reload after DONE.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        valid;
  logic [7:0]  data;
  logic        byte_ready;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [31:0] pm_data;
  logic        core_reset;
  logic        done;
  logic        error;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0]  sa[$];
  logic [31:0] sd[$];
  logic [7:0]  pkt[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(8), .MAX_WORDS(64)) dut (
    .clk              (clk),
    .reset_i          (reset),
    .start_i          (start),
    .byte_valid_i     (valid),
    .byte_data_i      (data),
    .byte_ready_o     (byte_ready),
    .pm_write_enable_o(pm_we),
    .pm_address_o     (pm_addr),
    .pm_write_data_o  (pm_data),
    .core_reset_o     (core_reset),
    .done_o           (done),
    .error_o          (error)
  );

  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      sa.push_back(pm_addr);
      sd.push_back(pm_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit poke);
    int n;
    n = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      valid = 1'b0;
      start = poke && (i == 0);
    end
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    data  = b;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_pkt(input logic [7:0] len, input logic [7:0] cs,
                         input bit rnd, input bit poke);
    int g;
    sa.delete();
    sd.delete();
    g = rnd ? int'($urandom_range(0, 3)) : 0;
    send_byte(len, g, 1'b0);
    foreach (pkt[i]) begin
      g = rnd ? int'($urandom_range(0, 3)) : 0;
      if (poke && i == 5) g = 2;
      send_byte(pkt[i], g, poke && i == 5);
    end
    if (pkt.size() > 0) send_byte(cs, 0, 1'b0);
    idle();
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({p, "_we"}, {31'd0, pm_we}, 32'd0);
    chk({p, "_addr"}, {24'd0, pm_addr}, 32'd0);
    chk({p, "_data"}, pm_data, 32'd0);
    chk({p, "_core_rst"}, {31'd0, core_reset}, 32'd1);
    chk({p, "_done"}, {31'd0, done}, 32'd0);
    chk({p, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic chk_good2(input string p);
    chk({p, "_nstrobe"}, sa.size(), 32'd2);
    if (sa.size() == 2) begin
      chk({p, "_a0"}, {24'd0, sa[0]}, 32'h00);
      chk({p, "_d0"}, sd[0], 32'h44332211);
      chk({p, "_a1"}, {24'd0, sa[1]}, 32'h04);
      chk({p, "_d1"}, sd[1], 32'hDDCCBBAA);
    end
    chk({p, "_done"}, {31'd0, done}, 32'd1);
    chk({p, "_core_rst"}, {31'd0, core_reset}, 32'd0);
    chk({p, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");

    // Bytes offered in IDLE, then start together with a valid byte.
    valid = 1'b1;
    data  = 8'h07;
    repeat (3) @(negedge clk);
    chk("pre_ready", {31'd0, byte_ready}, 32'd0);
    chk("pre_nstrobe", sa.size(), 32'd0);
    start_load();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_pkt(8'h02, 8'h44, 1'b0, 1'b0);
    chk_good2("good");

    // Reload after DONE.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reload_core_rst", {31'd0, core_reset}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    pkt = '{8'h05, 8'h00, 8'hA0, 8'hE3};
    run_pkt(8'h01, 8'h46, 1'b0, 1'b0);
    chk("reload_nstrobe", sa.size(), 32'd1);
    if (sa.size() == 1) begin
      chk("reload_a0", {24'd0, sa[0]}, 32'h00);
      chk("reload_d0", sd[0], 32'hE3A00005);
    end
    chk("reload_done2", {31'd0, done}, 32'd1);

    // Bad checksum.
    start_load();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_pkt(8'h02, 8'h5A, 1'b0, 1'b0);
    chk("bad_nstrobe", sa.size(), 32'd2);
    chk("bad_error", {31'd0, error}, 32'd1);
    chk("bad_core_rst", {31'd0, core_reset}, 32'd1);
    chk("bad_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("errclr_error", {31'd0, error}, 32'd0);

    // Zero length.
    pkt.delete();
    run_pkt(8'h00, 8'h00, 1'b0, 1'b0);
    chk("len0_error", {31'd0, error}, 32'd1);
    chk("len0_nstrobe", sa.size(), 32'd0);

    // Length above MAX_WORDS.
    start_load();
    run_pkt(8'd65, 8'h00, 1'b0, 1'b0);
    chk("len65_error", {31'd0, error}, 32'd1);
    chk("len65_nstrobe", sa.size(), 32'd0);

    // Full 64-word load, bytes 0..255; their XOR is 0.
    start_load();
    for (int i = 0; i < 256; i++) pkt.push_back(8'(i));
    run_pkt(8'd64, 8'h00, 1'b0, 1'b0);
    chk("len64_nstrobe", sa.size(), 32'd64);
    if (sa.size() == 64) begin
      chk("len64_d0", sd[0], 32'h03020100);
      chk("len64_alast", {24'd0, sa[63]}, 32'hFC);
      chk("len64_dlast", sd[63], 32'hFFFEFDFC);
    end
    chk("len64_done", {31'd0, done}, 32'd1);

    // Random gaps plus a start pulse mid-payload.
    start_load();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_pkt(8'h02, 8'h44, 1'b1, 1'b1);
    chk_good2("gaps");

    // Reset one cycle after the 6th payload byte.
    start_load();
    sa.delete();
    sd.delete();
    send_byte(8'h02, 0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(pkt[i], 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midrst");
    repeat (5) @(negedge clk);
    chk("midrst_nstrobe", sa.size(), 32'd1);

    start_load();
    run_pkt(8'h02, 8'h44, 1'b0, 1'b0);
    chk_good2("after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
